// File: rtl/pmem_arbiter.sv
// Two-port physical-memory arbiter: serialises I-cache and D-cache line transactions onto one
// pmem port, round-robin on simultaneous requests, with a one-cycle bubble after each completion.
module pmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic LAST_I = 1'b0;
  localparam logic LAST_D = 1'b1;

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic              pmem_read_q, pmem_read_d;
  logic              pmem_write_q, pmem_write_d;
  logic [ADDR_W-1:0] pmem_address_q, pmem_address_d;
  logic [LINE_W-1:0] pmem_wdata_q, pmem_wdata_d;

  logic req_i;
  logic req_d;
  logic grant_d;

  assign req_i   = i_pmem_read;
  assign req_d   = d_pmem_read | d_pmem_write;
  // On a tie the side that did not win last time gets the port.
  assign grant_d = req_d & (~req_i | (last_q == LAST_I));

  always_comb begin
    state_d        = state_q;
    last_d         = last_q;
    pmem_read_d    = pmem_read_q;
    pmem_write_d   = pmem_write_q;
    pmem_address_d = pmem_address_q;
    pmem_wdata_d   = pmem_wdata_q;
    i_pmem_resp    = 1'b0;
    d_pmem_resp    = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d        = GRANT_D;
          last_d         = LAST_D;
          pmem_address_d = d_pmem_address;
          pmem_wdata_d   = d_pmem_wdata;
          // A simultaneous read+write from the D side is issued as a write.
          pmem_write_d   = d_pmem_write;
          pmem_read_d    = ~d_pmem_write;
        end else if (req_i) begin
          state_d        = GRANT_I;
          last_d         = LAST_I;
          pmem_address_d = i_pmem_address;
          pmem_read_d    = 1'b1;
          pmem_write_d   = 1'b0;
        end
      end
      GRANT_I: begin
        if (pmem_resp) begin
          i_pmem_resp  = 1'b1;
          state_d      = DONE;
          pmem_read_d  = 1'b0;
          pmem_write_d = 1'b0;
        end
      end
      GRANT_D: begin
        if (pmem_resp) begin
          d_pmem_resp  = 1'b1;
          state_d      = DONE;
          pmem_read_d  = 1'b0;
          pmem_write_d = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      last_q         <= LAST_I;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
    end else begin
      state_q        <= state_d;
      last_q         <= last_d;
      pmem_read_q    <= pmem_read_d;
      pmem_write_q   <= pmem_write_d;
      pmem_address_q <= pmem_address_d;
      pmem_wdata_q   <= pmem_wdata_d;
    end
  end

  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = pmem_wdata_q;
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;
  assign dbg_state    = state_q;

  always @(posedge clk) begin
    if (rst && (state_q == IDLE)) begin
      assert (!(d_pmem_read && d_pmem_write))
        else $warning("pmem_arbiter: d_pmem_read and d_pmem_write both set, issuing write");
    end
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: inputs driven 1ns after the rising edge, outputs checked
// after they settle; the pmem side is played by the bench with hand-timed responses.
module tb_pmem_arbiter;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANT_I = 2'd1;
  localparam logic [1:0] S_GRANT_D = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic              clk;
  logic              rst;
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              p_read;
  logic              p_write;
  logic [ADDR_W-1:0] p_addr;
  logic [LINE_W-1:0] p_wdata;
  logic [LINE_W-1:0] p_rdata;
  logic              p_resp;
  logic [1:0]        dbg_state;

  int errors = 0;
  int checks = 0;

  logic [LINE_W-1:0] line_a5;
  logic [LINE_W-1:0] line_beef;
  logic [LINE_W-1:0] line_alt;

  pmem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_pmem_read    (i_read),
    .i_pmem_address (i_addr),
    .i_pmem_rdata   (i_rdata),
    .i_pmem_resp    (i_resp),
    .d_pmem_read    (d_read),
    .d_pmem_write   (d_write),
    .d_pmem_address (d_addr),
    .d_pmem_wdata   (d_wdata),
    .d_pmem_rdata   (d_rdata),
    .d_pmem_resp    (d_resp),
    .pmem_read      (p_read),
    .pmem_write     (p_write),
    .pmem_address   (p_addr),
    .pmem_wdata     (p_wdata),
    .pmem_rdata     (p_rdata),
    .pmem_resp      (p_resp),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    #2 rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (p_read !== 1'b0 || p_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes: read=%b write=%b, required 0 0", p_read, p_write);
    end
    checks++;
    if (p_addr !== '0 || p_wdata !== '0) begin
      errors++;
      $display("FAIL reset_addr_data: addr=%h, required 0 (wdata nonzero=%b)", p_addr, |p_wdata);
    end
    checks++;
    if (i_resp !== 1'b0 || d_resp !== 1'b0 || dbg_state !== S_IDLE) begin
      errors++;
      $display("FAIL reset_resp_state: i_resp=%b d_resp=%b state=%0d, required 0 0 0",
               i_resp, d_resp, dbg_state);
    end
    step();
    step();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_i_only();
    i_read = 1'b1;
    i_addr = 32'h0000_1000;
    step();
    checks++;
    if (p_read !== 1'b1 || p_write !== 1'b0 || p_addr !== 32'h0000_1000 || dbg_state !== S_GRANT_I) begin
      errors++;
      $display("FAIL i_grant: read=%b write=%b addr=%h state=%0d, required 1 0 00001000 1",
               p_read, p_write, p_addr, dbg_state);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (p_read !== 1'b1 || p_addr !== 32'h0000_1000 || i_resp !== 1'b0) begin
        errors++;
        $display("FAIL i_hold[%0d]: read=%b addr=%h i_resp=%b, required 1 00001000 0",
                 k, p_read, p_addr, i_resp);
      end
    end
    p_rdata = line_a5;
    p_resp  = 1'b1;
    #1;
    checks++;
    if (i_resp !== 1'b1 || i_rdata !== line_a5 || d_resp !== 1'b0) begin
      errors++;
      $display("FAIL i_resp: i_resp=%b d_resp=%b rdata_ok=%b, required 1 0 1",
               i_resp, d_resp, (i_rdata === line_a5));
    end
    step();
    p_resp = 1'b0;
    i_read = 1'b0;
    #1;
    checks++;
    if (dbg_state !== S_DONE || p_read !== 1'b0 || i_resp !== 1'b0) begin
      errors++;
      $display("FAIL i_done: state=%0d read=%b i_resp=%b, required 3 0 0", dbg_state, p_read, i_resp);
    end
    step();
    checks++;
    if (dbg_state !== S_IDLE) begin
      errors++;
      $display("FAIL i_idle: state=%0d, required 0", dbg_state);
    end
  endtask

  task automatic test_d_writeback();
    d_write = 1'b1;
    d_addr  = 32'h0000_2020;
    d_wdata = line_beef;
    step();
    checks++;
    if (p_write !== 1'b1 || p_read !== 1'b0 || p_addr !== 32'h0000_2020 || p_wdata !== line_beef ||
        dbg_state !== S_GRANT_D) begin
      errors++;
      $display("FAIL d_grant: write=%b read=%b addr=%h wdata_ok=%b state=%0d, required 1 0 00002020 1 2",
               p_write, p_read, p_addr, (p_wdata === line_beef), dbg_state);
    end
    step();
    step();
    p_resp = 1'b1;
    #1;
    checks++;
    if (d_resp !== 1'b1 || i_resp !== 1'b0) begin
      errors++;
      $display("FAIL d_resp: d_resp=%b i_resp=%b, required 1 0", d_resp, i_resp);
    end
    step();
    p_resp  = 1'b0;
    d_write = 1'b0;
    #1;
    checks++;
    if (dbg_state !== S_DONE || p_write !== 1'b0 || d_resp !== 1'b0) begin
      errors++;
      $display("FAIL d_done: state=%0d write=%b d_resp=%b, required 3 0 0", dbg_state, p_write, d_resp);
    end
    step();
    checks++;
    if (dbg_state !== S_IDLE) begin
      errors++;
      $display("FAIL d_idle: state=%0d, required 0", dbg_state);
    end
  endtask

  task automatic test_addr_stability();
    d_write = 1'b1;
    d_addr  = 32'h0000_2020;
    d_wdata = line_beef;
    step();
    d_addr  = 32'hFFFF_FFE0;
    d_wdata = line_alt;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (p_addr !== 32'h0000_2020 || p_wdata !== line_beef || p_write !== 1'b1) begin
        errors++;
        $display("FAIL stable[%0d]: addr=%h wdata_ok=%b write=%b, required 00002020 1 1",
                 k, p_addr, (p_wdata === line_beef), p_write);
      end
    end
    p_resp = 1'b1;
    #1;
    step();
    p_resp  = 1'b0;
    d_write = 1'b0;
    step();
  endtask

  task automatic test_back_to_back_ties();
    logic [ADDR_W-1:0] exp_addr;
    apply_reset();
    i_read = 1'b1;
    i_addr = 32'h0000_0100;
    d_read = 1'b1;
    d_addr = 32'h0000_0200;
    for (int k = 0; k < 4; k++) begin
      // Order after reset must be D, I, D, I.
      exp_addr = (k % 2 == 0) ? 32'h0000_0200 : 32'h0000_0100;
      step();
      checks++;
      if (p_addr !== exp_addr || p_read !== 1'b1 ||
          dbg_state !== ((k % 2 == 0) ? S_GRANT_D : S_GRANT_I)) begin
        errors++;
        $display("FAIL tie_grant[%0d]: addr=%h state=%0d read=%b, required %h %0d 1",
                 k, p_addr, dbg_state, p_read, exp_addr, (k % 2 == 0) ? 2 : 1);
      end
      p_resp = 1'b1;
      #1;
      checks++;
      if (d_resp !== (k % 2 == 0) || i_resp !== (k % 2 == 1)) begin
        errors++;
        $display("FAIL tie_resp[%0d]: d_resp=%b i_resp=%b, required %b %b",
                 k, d_resp, i_resp, (k % 2 == 0), (k % 2 == 1));
      end
      step();
      p_resp = 1'b0;
      #1;
      checks++;
      if (dbg_state !== S_DONE || p_read !== 1'b0 || i_resp !== 1'b0 || d_resp !== 1'b0) begin
        errors++;
        $display("FAIL tie_done[%0d]: state=%0d read=%b i_resp=%b d_resp=%b, required 3 0 0 0",
                 k, dbg_state, p_read, i_resp, d_resp);
      end
      step();
    end
    i_read = 1'b0;
    d_read = 1'b0;
    #1;
  endtask

  task automatic test_reset_mid_op();
    d_write = 1'b1;
    d_addr  = 32'h0000_4040;
    d_wdata = line_beef;
    step();
    checks++;
    if (p_write !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: write=%b, required 1", p_write);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (p_write !== 1'b0 || p_read !== 1'b0 || p_addr !== '0 || dbg_state !== S_IDLE) begin
      errors++;
      $display("FAIL rst_async: write=%b read=%b addr=%h state=%0d, required 0 0 0 0",
               p_write, p_read, p_addr, dbg_state);
    end
    step();
    rst     = 1'b1;
    d_write = 1'b0;
    p_resp  = 1'b1;
    #1;
    checks++;
    if (i_resp !== 1'b0 || d_resp !== 1'b0) begin
      errors++;
      $display("FAIL rst_stray_resp: i_resp=%b d_resp=%b, required 0 0", i_resp, d_resp);
    end
    step();
    checks++;
    if (dbg_state !== S_IDLE || p_write !== 1'b0 || p_read !== 1'b0) begin
      errors++;
      $display("FAIL rst_after: state=%0d write=%b read=%b, required 0 0 0", dbg_state, p_write, p_read);
    end
    p_resp = 1'b0;
    #1;
  endtask

  task automatic test_spurious_illegal();
    p_resp = 1'b1;
    #1;
    checks++;
    if (i_resp !== 1'b0 || d_resp !== 1'b0) begin
      errors++;
      $display("FAIL idle_resp: i_resp=%b d_resp=%b, required 0 0", i_resp, d_resp);
    end
    step();
    checks++;
    if (dbg_state !== S_IDLE) begin
      errors++;
      $display("FAIL idle_stay: state=%0d, required 0", dbg_state);
    end
    p_resp  = 1'b0;
    d_read  = 1'b1;
    d_write = 1'b1;
    d_addr  = 32'h0000_3000;
    d_wdata = line_alt;
    step();
    d_read  = 1'b0;
    d_write = 1'b0;
    checks++;
    if (p_write !== 1'b1 || p_read !== 1'b0 || p_addr !== 32'h0000_3000 || dbg_state !== S_GRANT_D) begin
      errors++;
      $display("FAIL rw_as_write: write=%b read=%b addr=%h state=%0d, required 1 0 00003000 2",
               p_write, p_read, p_addr, dbg_state);
    end
    p_resp = 1'b1;
    #1;
    checks++;
    if (d_resp !== 1'b1) begin
      errors++;
      $display("FAIL rw_resp: d_resp=%b, required 1", d_resp);
    end
    step();
    checks++;
    if (dbg_state !== S_DONE || d_resp !== 1'b0 || i_resp !== 1'b0) begin
      errors++;
      $display("FAIL done_resp_ignored: state=%0d d_resp=%b i_resp=%b, required 3 0 0",
               dbg_state, d_resp, i_resp);
    end
    p_resp = 1'b0;
    step();
  endtask

  initial begin
    rst       = 1'b1;
    i_read    = 1'b0;
    i_addr    = '0;
    d_read    = 1'b0;
    d_write   = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    p_rdata   = '0;
    p_resp    = 1'b0;
    line_a5   = {8{32'hA5A5_A5A5}};
    line_beef = {8{32'hDEAD_BEEF}};
    line_alt  = {8{32'h1234_5678}};

    test_reset();
    test_i_only();
    test_d_writeback();
    test_addr_stability();
    test_back_to_back_ties();
    test_reset_mid_op();
    test_spurious_illegal();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at %0t, required completion", $time);
    $fatal(1, "timeout");
  end

endmodule
